dcache_array: RTL and testbench



---
 rtl/dcache_array_if.sv | 36 +++
 rtl/dcache_array.sv | 140 ++++++++++++++
 tb/tb_dcache_array.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/dcache_array_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcache_array_if : command/lookup bus between the D$ controller and its arrays
// Rev 1.0
// ---------------------------------------------------------------------------
interface dcache_array_if #(
  parameter int LINE_WIDTH  = 128,
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH   = 26
);
  localparam int WORD_SEL_WIDTH = $clog2(LINE_WIDTH / 32);

  logic                      ready;
  logic [1:0]                command;
  logic [INDEX_WIDTH-1:0]    index;
  logic [TAG_WIDTH-1:0]      tag;
  logic [WORD_SEL_WIDTH-1:0] wordIndex;
  logic [31:0]               writeData;
  logic [3:0]                writeMask;
  logic [LINE_WIDTH-1:0]     replaceLine;
  logic                      readValid;
  logic [TAG_WIDTH-1:0]      readTag;
  logic [LINE_WIDTH-1:0]     readLine;
  logic                      hit;

  modport master (
    input  ready, readValid, readTag, readLine, hit,
    output command, index, tag, wordIndex, writeData, writeMask, replaceLine
  );

  modport slave (
    output ready, readValid, readTag, readLine, hit,
    input  command, index, tag, wordIndex, writeData, writeMask, replaceLine
  );
endinterface
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dcache_array : tag/valid/data storage of the direct-mapped D$ with a
//                post-reset valid sweep and registered lookup
// Rev 1.0
// ---------------------------------------------------------------------------
module dcache_array #(
  parameter int LINE_WIDTH  = 128,
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH   = 26
) (
  input  logic           clk,
  input  logic           rst,
  dcache_array_if.slave  bus
);
  localparam int DEPTH = 1 << INDEX_WIDTH;

  localparam logic [1:0] c_cmd_write_through = 2'd1;
  localparam logic [1:0] c_cmd_replace       = 2'd2;
  localparam logic [1:0] c_cmd_invalidate    = 2'd3;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_SWEEP = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [INDEX_WIDTH-1:0] r_sweep_cnt;
  logic [INDEX_WIDTH-1:0] w_sweep_cnt_next;

  logic [DEPTH-1:0]       r_valid;
  logic [TAG_WIDTH-1:0]   r_tag  [DEPTH];
  logic [LINE_WIDTH-1:0]  r_data [DEPTH];

  logic                   w_ready;
  logic                   w_cur_valid;
  logic [TAG_WIDTH-1:0]   w_cur_tag;
  logic [LINE_WIDTH-1:0]  w_cur_line;
  logic                   w_hit;
  logic [LINE_WIDTH-1:0]  w_wt_line;

  logic                   r_read_valid;
  logic [TAG_WIDTH-1:0]   r_read_tag;
  logic [LINE_WIDTH-1:0]  r_read_line;
  logic                   r_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RESET;
      r_sweep_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_sweep_cnt <= w_sweep_cnt_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_sweep_cnt_next = r_sweep_cnt;
    case (r_state)
      ST_RESET: w_state_next = ST_SWEEP;
      ST_SWEEP: begin
        w_sweep_cnt_next = r_sweep_cnt + 1'b1;
        if (&r_sweep_cnt) w_state_next = ST_READY;
      end
      ST_READY: w_state_next = ST_READY;
      default:  w_state_next = ST_RESET;
    endcase
  end

  // Gating with rst keeps a command presented in the reset cycle from landing.
  assign w_ready     = (r_state == ST_READY) && !rst;

  assign w_cur_valid = r_valid[bus.index];
  assign w_cur_tag   = r_tag[bus.index];
  assign w_cur_line  = r_data[bus.index];
  assign w_hit       = w_cur_valid && (w_cur_tag == bus.tag);

  always_comb begin
    w_wt_line = w_cur_line;
    for (int b = 0; b < 4; b++) begin
      if (bus.writeMask[b])
        w_wt_line[32*int'(bus.wordIndex) + 8*b +: 8] = bus.writeData[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_SWEEP) begin
        r_valid[r_sweep_cnt] <= 1'b0;
      end else if (w_ready) begin
        case (bus.command)
          c_cmd_replace:    r_valid[bus.index] <= 1'b1;
          c_cmd_invalidate: r_valid[bus.index] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Tag and data are never reset; only the valid bits are swept.
  always_ff @(posedge clk) begin
    if (w_ready) begin
      case (bus.command)
        c_cmd_write_through: begin
          if (w_hit) r_data[bus.index] <= w_wt_line;
        end
        c_cmd_replace: begin
          r_data[bus.index] <= bus.replaceLine;
          r_tag[bus.index]  <= bus.tag;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read_valid <= 1'b0;
      r_read_tag   <= '0;
      r_read_line  <= '0;
      r_hit        <= 1'b0;
    end else begin
      r_read_valid <= w_cur_valid;
      r_read_tag   <= w_cur_tag;
      r_read_line  <= w_cur_line;
      r_hit        <= w_hit;
    end
  end

  assign bus.ready     = w_ready;
  assign bus.readValid = r_read_valid;
  assign bus.readTag   = r_read_tag;
  assign bus.readLine  = r_read_line;
  assign bus.hit       = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_dcache_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dcache_array : directed plus randomized checks against a line-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dcache_array;
  localparam int LW = 128;
  localparam int IW = 4;
  localparam int TW = 26;
  localparam int NL = 1 << IW;

  localparam logic [1:0] NONE  = 2'd0;
  localparam logic [1:0] WT    = 2'd1;
  localparam logic [1:0] RPL   = 2'd2;
  localparam logic [1:0] INVAL = 2'd3;

  logic clk;
  logic rst;

  dcache_array_if #(.LINE_WIDTH(LW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW)) bus ();

  dcache_array #(.LINE_WIDTH(LW), .INDEX_WIDTH(IW), .TAG_WIDTH(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: line contents plus the number of rst=0 cycles since the last reset.
  logic          m_valid   [NL];
  logic          m_written [NL];
  logic [TW-1:0] m_tag     [NL];
  logic [LW-1:0] m_data    [NL];
  int            m_live;

  int n_checks;
  int n_fail;

  task automatic check_eq(input string name, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] cmd, input logic [IW-1:0] idx,
                      input logic [TW-1:0] tg, input logic [1:0] wi, input logic [31:0] wd,
                      input logic [3:0] wm, input logic [LW-1:0] rl);
    logic          en;
    logic          e_valid;
    logic          e_hit;
    logic          e_known;
    logic [TW-1:0] e_tag;
    logic [LW-1:0] e_line;
    rst             = r;
    bus.command     = cmd;
    bus.index       = idx;
    bus.tag         = tg;
    bus.wordIndex   = wi;
    bus.writeData   = wd;
    bus.writeMask   = wm;
    bus.replaceLine = rl;
    #1;
    en = !r && (m_live >= NL + 1);
    check_eq("ready", LW'(bus.ready), LW'(en));
    e_valid = m_valid[idx];
    e_hit   = m_valid[idx] && (m_tag[idx] == tg);
    e_known = m_written[idx];
    e_tag   = m_tag[idx];
    e_line  = m_data[idx];
    if (en) begin
      case (cmd)
        WT: if (e_hit) begin
          for (int b = 0; b < 4; b++)
            if (wm[b]) m_data[idx][wi*32 + b*8 +: 8] = wd[b*8 +: 8];
        end
        RPL: begin
          m_data[idx] = rl; m_tag[idx] = tg; m_valid[idx] = 1'b1; m_written[idx] = 1'b1;
        end
        INVAL: m_valid[idx] = 1'b0;
        default: ;
      endcase
    end
    if (r) begin
      m_live = 0;
      for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    end else begin
      m_live++;
    end
    @(posedge clk);
    #1;
    if (r) begin
      check_eq("rst_rvalid", LW'(bus.readValid), '0);
      check_eq("rst_hit",    LW'(bus.hit), '0);
      check_eq("rst_rtag",   LW'(bus.readTag), '0);
      check_eq("rst_rline",  bus.readLine, '0);
    end else if (en) begin
      check_eq("rvalid", LW'(bus.readValid), LW'(e_valid));
      check_eq("hit",    LW'(bus.hit), LW'(e_hit));
      if (e_known) begin
        check_eq("rtag",  LW'(bus.readTag), LW'(e_tag));
        check_eq("rline", bus.readLine, e_line);
      end
    end
  endtask

  task automatic look(input logic [IW-1:0] idx, input logic [TW-1:0] tg);
    step(1'b0, NONE, idx, tg, 2'd0, 32'd0, 4'd0, '0);
  endtask

  localparam logic [LW-1:0] L5 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  initial begin
    logic [LW-1:0] tmp;
    logic [IW-1:0] ri;
    logic [TW-1:0] rt;
    n_checks = 0;
    n_fail   = 0;
    m_live   = 0;
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = 1'b0; m_written[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end
    rst = 1'b1;
    bus.command = NONE; bus.index = '0; bus.tag = '0; bus.wordIndex = '0;
    bus.writeData = '0; bus.writeMask = '0; bus.replaceLine = '0;
    @(posedge clk);
    #1;

    // Reset and full sweep, then every line must read invalid.
    for (int i = 0; i < 3; i++) step(1'b1, NONE, 4'd0, '0, 2'd0, 32'd0, 4'd0, '0);
    for (int i = 0; i < NL + 1; i++) look(4'(i), '0);
    for (int i = 0; i < NL; i++) look(4'(i), 26'h0);
    look(4'd0, '0);

    // Replace then lookup, hit and tag miss.
    step(1'b0, RPL, 4'd5, 26'h1234567, 2'd0, 32'd0, 4'd0, L5);
    look(4'd5, 26'h1234567);
    check_eq("rpl_hit",  LW'(bus.hit), 1);
    check_eq("rpl_line", bus.readLine, L5);
    look(4'd5, 26'h1234568);
    check_eq("tagmiss_hit",    LW'(bus.hit), 0);
    check_eq("tagmiss_rvalid", LW'(bus.readValid), 1);

    // WriteThrough hit merges bytes 0 and 2; a miss leaves the line alone.
    step(1'b0, WT, 4'd5, 26'h1234567, 2'd2, 32'hDEADBEEF, 4'b0101, '0);
    look(4'd5, 26'h1234567);
    tmp = bus.readLine;
    check_eq("wt_word2", LW'(tmp[95:64]), LW'(32'h89AD_CDEF));
    step(1'b0, WT, 4'd5, 26'h0000001, 2'd2, 32'h11223344, 4'b1111, '0);
    look(4'd5, 26'h1234567);
    tmp = bus.readLine;
    check_eq("wtmiss_word2", LW'(tmp[95:64]), LW'(32'h89AD_CDEF));

    // Invalidate keeps data.
    step(1'b0, INVAL, 4'd5, 26'h1234567, 2'd0, 32'd0, 4'd0, '0);
    look(4'd5, 26'h1234567);
    check_eq("inv_rvalid", LW'(bus.readValid), 0);
    check_eq("inv_hit",    LW'(bus.hit), 0);
    tmp = bus.readLine;
    check_eq("inv_data", LW'(tmp[95:64]), LW'(32'h89AD_CDEF));

    // Read-before-write on index 3.
    step(1'b0, RPL, 4'd3, 26'h00000AA, 2'd0, 32'd0, 4'd0, {4{32'hAAAA_0001}});
    step(1'b0, RPL, 4'd3, 26'h00000BB, 2'd0, 32'd0, 4'd0, {4{32'hBBBB_0002}});
    check_eq("rbw_old", bus.readLine, {4{32'hAAAA_0001}});
    look(4'd3, 26'h00000BB);
    check_eq("rbw_new", bus.readLine, {4{32'hBBBB_0002}});
    check_eq("rbw_hit", LW'(bus.hit), 1);

    // WriteThrough then Invalidate of the same line on consecutive cycles.
    step(1'b0, WT, 4'd3, 26'h00000BB, 2'd0, 32'h0000_00FF, 4'b0001, '0);
    step(1'b0, INVAL, 4'd3, 26'h00000BB, 2'd0, 32'd0, 4'd0, '0);
    look(4'd3, 26'h00000BB);

    // Reset during sweep cycle 8 restarts the full sequence.
    step(1'b1, NONE, 4'd0, '0, 2'd0, 32'd0, 4'd0, '0);
    for (int i = 0; i < 8; i++) look(4'd0, '0);
    step(1'b1, NONE, 4'd0, '0, 2'd0, 32'd0, 4'd0, '0);
    for (int i = 0; i < NL + 2; i++) look(4'd0, '0);

    // Reset with valid lines; commands during the sweep are dropped.
    step(1'b0, RPL, 4'd1, 26'h0000111, 2'd0, 32'd0, 4'd0, {4{32'h1111_1111}});
    step(1'b0, RPL, 4'd2, 26'h0000222, 2'd0, 32'd0, 4'd0, {4{32'h2222_2222}});
    step(1'b1, RPL, 4'd7, 26'h0000777, 2'd0, 32'd0, 4'd0, {4{32'h7777_7777}});
    for (int i = 0; i < NL + 1; i++)
      step(1'b0, (i % 2 == 0) ? RPL : WT, 4'(i), 26'h0000111, 2'(i), 32'hCAFE_F00D,
           4'hF, {4{32'h5555_5555}});
    for (int i = 0; i < NL; i++) begin
      look(4'(i), 26'h0000111);
      check_eq("post_rst_invalid", LW'(bus.readValid), 0);
    end

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      ri = 4'($urandom_range(0, NL - 1));
      rt = ($urandom_range(0, 2) != 0 && m_written[ri]) ? m_tag[ri] : 26'($urandom);
      step(($urandom_range(0, 199) == 0), 2'($urandom_range(0, 3)), ri, rt,
           2'($urandom_range(0, 3)), 32'($urandom), 4'($urandom_range(0, 15)),
           {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
